// File: rtl/contador_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_pkg: mode and state encodings shared by the counter bank.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package contador_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_FREE    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd2;
  localparam logic [MODE_W-1:0] MODE_DOWN    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/contador_canal.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_canal: one programmable counter channel with limit and mode. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module contador_canal
  import contador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [WIDTH-1:0]  cfg_max,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic              enable,
  input  logic              clear,
  output logic [WIDTH-1:0]  count,
  output logic              bigger_than_max,
  output logic              terminal,
  output logic              done
);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  state_e            state_q, state_d;
  logic              terminal_q, terminal_d;
  logic              done_q, done_d;

  always_comb begin
    count_d    = count_q;
    limit_d    = limit_q;
    mode_d     = mode_q;
    state_d    = state_q;
    terminal_d = 1'b0;
    done_d     = done_q;
    if (cfg_we) begin
      limit_d = cfg_max;
      mode_d  = cfg_mode;
      count_d = (cfg_mode == MODE_DOWN) ? cfg_max : '0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (clear && (state_q != ST_IDLE)) begin
      count_d = (mode_q == MODE_DOWN) ? limit_q : '0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && enable) begin
      case (mode_q)
        MODE_FREE: begin
          count_d    = count_q + WIDTH'(1);
          terminal_d = (count_q == '1);
        end
        MODE_RELOAD: begin
          if (count_q == limit_q) begin
            count_d    = '0;
            terminal_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_ONESHOT: begin
          if (count_q == limit_q) begin
            state_d    = ST_HALT;
            done_d     = 1'b1;
            terminal_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: begin
          // Down-count reloads from the limit after reaching zero.
          if (count_q == '0) begin
            count_d    = limit_q;
            terminal_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      limit_q    <= '1;
      mode_q     <= MODE_FREE;
      state_q    <= ST_IDLE;
      terminal_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      limit_q    <= limit_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      terminal_q <= terminal_d;
      done_q     <= done_d;
    end
  end

  assign count           = count_q;
  assign bigger_than_max = (state_q != ST_IDLE) && (count_q >= limit_q);
  assign terminal        = terminal_q;
  assign done            = done_q;

endmodule
`default_nettype wire

// File: rtl/contador_canais.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_canais: bank of programmable counters behind one cfg port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module contador_canais
  import contador_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CW-1:0]             cfg_chan,
  input  logic [WIDTH-1:0]          cfg_max,
  input  logic [MODE_W-1:0]         cfg_mode,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       bigger_than_max,
  output logic [CHANNELS-1:0]       terminal,
  output logic [CHANNELS-1:0]       done
);

  logic cfg_ready_q, cfg_ready_d;
  logic accept;

  assign accept = cfg_valid && cfg_ready_q;

  // One bubble after every accept, so back-to-back requests alternate.
  always_comb begin
    cfg_ready_d = !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic we;
    assign we = accept && (cfg_chan == CW'(i));

    contador_canal #(
      .WIDTH(WIDTH)
    ) u_canal (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_we         (we),
      .cfg_max        (cfg_max),
      .cfg_mode       (cfg_mode),
      .enable         (enable[i]),
      .clear          (clear[i]),
      .count          (count[i*WIDTH +: WIDTH]),
      .bigger_than_max(bigger_than_max[i]),
      .terminal       (terminal[i]),
      .done           (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_contador_canais.sv
`default_nettype none
// Scoreboard bench for contador_canais (WIDTH=3, CHANNELS=2) plus a
// three-channel instance for out-of-range channel decode.
module tb_contador_canais;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_chan = 1'b0;
  logic [2:0] cfg_max = 3'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] enable = 2'b00;
  logic [1:0] clear = 2'b00;
  logic [5:0] count;
  logic [1:0] btm, term, done;

  logic       d3_valid = 1'b0;
  logic       d3_ready;
  logic [1:0] d3_chan = 2'd0;
  logic [2:0] d3_max = 3'd0;
  logic [1:0] d3_mode = 2'd0;
  logic [8:0] d3_count;
  logic [2:0] d3_btm, d3_term, d3_done;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      nm;
    logic [12:0] v;
  } exp_t;
  exp_t sb[$];

  contador_canais #(.WIDTH(3), .CHANNELS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
    .enable(enable), .clear(clear), .count(count),
    .bigger_than_max(btm), .terminal(term), .done(done)
  );

  contador_canais #(.WIDTH(3), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(d3_valid), .cfg_ready(d3_ready),
    .cfg_chan(d3_chan), .cfg_max(d3_max), .cfg_mode(d3_mode),
    .enable(3'b111), .clear(3'b000), .count(d3_count),
    .bigger_than_max(d3_btm), .terminal(d3_term), .done(d3_done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endfunction

  function automatic logic [12:0] dut_vec();
    return {count, btm, term, done, cfg_ready};
  endfunction

  // Expected ch0 values after the coming edge; ch1 is never configured.
  task automatic tick(input string nm, input logic [2:0] c, input logic b,
                      input logic t, input logic d, input logic r);
    exp_t e;
    e.nm = nm;
    e.v  = {3'b000, c, 1'b0, b, 1'b0, t, 1'b0, d, r};
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic v, input logic [2:0] mx, input logic [1:0] md);
    cfg_valid = v;
    cfg_chan  = 1'b0;
    cfg_max   = mx;
    cfg_mode  = md;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.nm, {19'd0, dut_vec()}, {19'd0, e.v});
      end
    end
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {19'd0, dut_vec()}, 32'h1);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 2'b11;
    tick("idle_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // RELOAD, limit 5
    enable = 2'b01;
    set_cfg(1'b1, 3'd5, 2'd1);
    tick("rel_cfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    for (int k = 1; k <= 5; k++) tick("rel_cnt", 3'(k), (k == 5), 1'b0, 1'b0, 1'b1);
    tick("rel_wrap", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick("rel_after", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // ONESHOT, limit 3
    set_cfg(1'b1, 3'd3, 2'd2);
    tick("os_cfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    tick("os_1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("os_2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("os_3", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick("os_stop", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick("os_hold", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    clear = 2'b01;
    tick("os_clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear = 2'b00;
    tick("os_resume1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("os_resume2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    // DOWN, limit 4 then limit 0
    set_cfg(1'b1, 3'd4, 2'd3);
    tick("dn_cfg", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    for (int k = 3; k >= 0; k--) tick("dn_cnt", 3'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    tick("dn_reload", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick("dn_after", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(1'b1, 3'd0, 2'd3);
    tick("dn0_cfg", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 3; k++) tick("dn0_evt", 3'd0, 1'b1, 1'b1, 1'b0, k != 0 || 1'b1);
    enable = 2'b00;
    tick("dn0_disabled", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    enable = 2'b01;
    tick("dn0_again", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // FREE, limit 6
    set_cfg(1'b1, 3'd6, 2'd0);
    tick("fr_cfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    for (int k = 1; k <= 7; k++) tick("fr_cnt", 3'(k), (k >= 6), 1'b0, 1'b0, 1'b1);
    tick("fr_wrap", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick("fr_1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    enable = 2'b00;
    tick("fr_hold1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("fr_hold2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    enable = 2'b01;
    tick("fr_2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    // Handshake: valid held four cycles
    set_cfg(1'b1, 3'd7, 2'd1);
    tick("hs_acc0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("hs_gap1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("hs_acc2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("hs_gap3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(1'b0, 3'd0, 2'd0);
    for (int k = 2; k <= 4; k++) tick("hs_cnt", 3'(k), 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(1'b1, 3'd5, 2'd1);
    tick("mid_recfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    tick("mid_1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(1'b1, 3'd2, 2'd3);
    clear = 2'b01;
    tick("cfg_over_clr", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    clear = 2'b00;
    tick("cfg_over_clr_run", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Out-of-range channel on the three-channel instance
    enable   = 2'b00;
    d3_valid = 1'b1;
    d3_chan  = 2'd3;
    d3_max   = 3'd3;
    d3_mode  = 2'd1;
    tick("d3_hold_a", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("chan3_accept", {19'd0, d3_count, d3_btm, d3_ready}, 32'h0);
    d3_valid = 1'b0;
    tick("d3_hold_b", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("d3_hold_c", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("chan3_ignored", {19'd0, d3_count, d3_btm, d3_ready}, 32'h1);
    d3_valid = 1'b1;
    d3_chan  = 2'd2;
    tick("d3_hold_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    d3_valid = 1'b0;
    check("chan2_cfg", {19'd0, d3_count, d3_btm, d3_ready}, 32'h0);
    tick("d3_hold_e", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("chan2_count", {19'd0, d3_count, d3_btm, d3_ready}, {19'd0, 9'b001_000_000, 3'b000, 1'b1});

    // Reset mid-count with done set
    enable = 2'b01;
    set_cfg(1'b1, 3'd1, 2'd2);
    tick("rs_cfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    tick("rs_1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick("rs_done", 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_async", {19'd0, dut_vec()}, 32'h1);
    tick("rs_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick("rs_idle1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("rs_idle2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(1'b1, 3'd5, 2'd1);
    tick("rs_recfg", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 3'd0, 2'd0);
    tick("rs_run", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/contador_canais.md
# contador_canais

Parametrised multi-channel programmable counter: the successor to the single 3-bit threshold counter. Each of CHANNELS independent counters has its own limit and mode: free-run, auto-reload, one-shot or down-count. Each channel provides the at-or-above-limit flag, a terminal-count pulse and a sticky done flag. Limits are written through a valid/ready configuration port, so FSMs in the design can share one timer bank instead of instantiating one counter per delay.

## Interface
- WIDTH, 8: counter and limit width, ≥2.
- CHANNELS, 4: number of independent channels, ≥1.
- CW, max(1,$clog2(CHANNELS)): channel-index width (derived).
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while 0.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accept; transfer when cfg_valid && cfg_ready.
- cfg_chan  in  CW  target channel; values ≥CHANNELS accepted and ignored.
- cfg_max  in  WIDTH  new limit.
- cfg_mode  in  2  0 FREE, 1 RELOAD, 2 ONESHOT, 3 DOWN.
- enable  in  CHANNELS  per-channel count enable.
- clear  in  CHANNELS  per-channel synchronous restart.
- count  out  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH].
- bigger_than_max  out  CHANNELS  count ≥ limit.
- terminal  out  CHANNELS  one-cycle event pulse.
- done  out  CHANNELS  sticky one-shot completion.

## Operation
- Per-channel FSM: IDLE (unconfigured, count held 0), RUN, HALT (one-shot finished).
- Config accept on channel c: limit←cfg_max, mode←cfg_mode, count←0 (DOWN: count←cfg_max), done←0, state→RUN. Accepted from any state, including mid-count.
- Per-edge priority within a channel: reset > config accept > clear > enable.
- clear: count←0 (DOWN: ←limit), done←0, HALT→RUN; no effect in IDLE.
- Count rules apply in RUN with enable=1 and are unsigned modulo 2^WIDTH:
  - FREE: count+1, wraps all-ones→0; the limit is used only for bigger_than_max.
  - RELOAD: count==limit → 0, else count+1.
  - ONESHOT: count==limit → hold, state→HALT, done←1; else count+1.
  - DOWN: count==0 → limit, else count−1.
- Event = FREE wrap, RELOAD/DOWN reload, or ONESHOT stop.
- limit=0: RELOAD and DOWN hold at 0 and generate an event every enabled cycle. ONESHOT halts on its first enabled cycle.
- bigger_than_max = (count ≥ limit) combinationally from registered state; forced to 0 in IDLE.
- cfg_ready drops for exactly the one cycle after an accept, then returns to 1. Back-to-back requests are therefore taken every second cycle.

## Timing
- Reset values: count 0, limit all-ones, mode FREE, state IDLE, bigger_than_max 0, terminal 0, done 0, cfg_ready 1.
- Config latency is 1: the new limit, mode and count are visible in the cycle after the accept edge.
- terminal is registered. It is high for exactly the cycle after the edge that performed the event, then returns to 0 unless another event occurs.
- done rises in that same cycle and stays high until clear, config or reset.
- enable=0 freezes count and generates no events. clear and config act regardless of enable.
- Reset assertion mid-count clears everything asynchronously. The first count edge is the first rising edge with reset=1.

## Structure
- contador_pkg holds: mode encodings (MODE_FREE/RELOAD/ONESHOT/DOWN), state encodings (ST_IDLE/RUN/HALT) and the 2-bit mode width.
- Sub-module contador_canal (one channel: limit, mode, state, count, flags). It is instantiated CHANNELS times by generate.
- The top holds cfg_ready, channel decode and output packing.

## Test plan
WIDTH=3, CHANNELS=2.
- RELOAD, limit=5, ch0, enable held: count 0,1,2,3,4,5,0. bigger_than_max is high only at 5. terminal is high in the cycle count is back at 0. ch1 stays IDLE with all outputs 0.
- ONESHOT, limit=3: count goes to 3 and holds. terminal pulses once; done stays 1 for 10 further cycles. Then clear → count 0, done 0, counting resumes.
- DOWN, limit=4: count 4,3,2,1,0,4. terminal pulses after 0→4. bigger_than_max is high while count=4. With limit=0, terminal is high every enabled cycle.
- FREE, limit=6: count 0..7,0. terminal pulses after 7→0. bigger_than_max is high at 6 and 7. Toggling enable low holds the count.
- Config handshake: cfg_valid held 4 cycles gives accepts on cycles 0 and 2 and cfg_ready pattern 1,0,1,0. Reconfiguring ch0 mid-count at 4 restarts it from 0. Config and clear on the same edge: config wins. cfg_chan=3 is accepted and ignored.
- Reset pulse (reset=0) mid-count with done=1: count, done and terminal are 0 immediately. Counting resumes from 0 only after reconfiguration, because the channel is back in IDLE.
